// File: rtl/piso_tx_pkg.sv
// Purpose: shared types and defaults for the piso_tx serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piso_tx_pkg;

  // Serializer control state: waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Matches the 4-bit sipo_4 deserializer on the far side of the link.
  localparam int PISO_WIDTH_DEFAULT = 4;

endpackage : piso_tx_pkg

// File: rtl/piso_tx.sv
// Purpose: parallel-in serial-out transmitter, MSB first, one bit per clock.
// Latency: word accepted on edge N shows its first bit in cycle N+1, last in N+WIDTH.
// Backpressure: p_ready drops only while the one-entry holding register is full.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   p_in/p_valid     : parallel word in, valid/ready handshake
//   p_ready          : word accepted on any edge with p_valid && p_ready
//   s_out/s_valid    : serial bit and its qualifier (s_out is 0 when idle)
//   s_first/s_last   : marks on the MSB and LSB of each word
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_first,
  output logic             s_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;
  logic             accept;

  // Ready is withheld during reset so a word offered then is never taken.
  assign p_ready = !hold_full && !rst;
  assign accept  = p_valid && p_ready;

  // Outputs decode straight from registers; rst forces them quiet in the
  // cycle it is asserted, before the state register has cleared.
  assign s_valid = (state == SHIFT) && !rst;
  assign s_out   = sh[WIDTH-1] & s_valid;
  assign s_first = s_valid && (cnt == '0);
  assign s_last  = s_valid && (cnt == CNT_LAST);

  always_comb begin
    state_nxt     = state;
    sh_nxt        = sh;
    cnt_nxt       = cnt;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;

    unique case (state)
      IDLE: begin
        if (accept) begin
          sh_nxt    = p_in;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt != CNT_LAST) begin
          sh_nxt  = sh << 1;
          cnt_nxt = cnt + CNT_ONE;
          // hold is empty whenever accept is possible, so this never
          // overwrites a pending word.
          if (accept) begin
            hold_nxt      = p_in;
            hold_full_nxt = 1'b1;
          end
        end else begin
          // Last bit: reload from hold first, else bypass a fresh word
          // straight into the shifter so the stream has no idle slot.
          cnt_nxt = '0;
          if (hold_full) begin
            sh_nxt        = hold;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            sh_nxt = p_in;
          end else begin
            sh_nxt    = sh << 1;
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// Purpose: self-checking bench for piso_tx at WIDTH=4 and WIDTH=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       rst4, p_valid4, p_ready4, s_out4, s_valid4, s_first4, s_last4;
  logic [3:0] p_in4;
  // WIDTH=8 instance
  logic       rst8, p_valid8, p_ready8, s_out8, s_valid8, s_first8, s_last8;
  logic [7:0] p_in8;

  piso_tx #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .p_in(p_in4), .p_valid(p_valid4), .p_ready(p_ready4),
    .s_out(s_out4), .s_valid(s_valid4), .s_first(s_first4), .s_last(s_last4)
  );

  piso_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .p_in(p_in8), .p_valid(p_valid8), .p_ready(p_ready8),
    .s_out(s_out8), .s_valid(s_valid8), .s_first(s_first8), .s_last(s_last8)
  );

  bit sel8 = 1'b0;  // which instance is currently under test
  int W    = 4;

  logic g_rdy, g_vld, g_out, g_fst, g_lst;
  assign g_rdy = sel8 ? p_ready8 : p_ready4;
  assign g_vld = sel8 ? s_valid8 : s_valid4;
  assign g_out = sel8 ? s_out8   : s_out4;
  assign g_fst = sel8 ? s_first8 : s_first4;
  assign g_lst = sel8 ? s_last8  : s_last4;

  // Downstream left-shifting deserializer sampling the live serial line.
  logic [7:0] sipo = '0;
  always @(posedge clk) sipo <= {sipo[6:0], g_out};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a queue of bits still to appear on the line, in order.
  // The head is the bit shown this cycle; everything beyond one word's worth
  // of bits is a word waiting in the holding register.
  typedef struct {
    logic       b;
    logic       f;
    logic       l;
    logic [7:0] w;
  } ent_t;

  ent_t       q[$];
  bit         sipo_pend = 1'b0;
  logic [7:0] sipo_word = '0;

  task automatic step(input bit r, input bit v, input logic [7:0] d, output bit acc);
    ent_t       e;
    bit         has;
    logic [7:0] mask;
    if (sel8) begin
      rst8 = r; p_valid8 = v; p_in8 = d;
      rst4 = 1'b1; p_valid4 = 1'b0; p_in4 = '0;
    end else begin
      rst4 = r; p_valid4 = v; p_in4 = d[3:0];
      rst8 = 1'b1; p_valid8 = 1'b0; p_in8 = '0;
    end
    @(negedge clk);
    has  = !r && (q.size() > 0);
    e    = has ? q[0] : '{b: 1'b0, f: 1'b0, l: 1'b0, w: 8'h0};
    mask = 8'((1 << W) - 1);
    chk("p_ready", 32'(g_rdy), 32'(!r && (q.size() <= W)));
    chk("s_valid", 32'(g_vld), 32'(has));
    chk("s_out",   32'(g_out), 32'(has ? e.b : 1'b0));
    chk("s_first", 32'(g_fst), 32'(has ? e.f : 1'b0));
    chk("s_last",  32'(g_lst), 32'(has ? e.l : 1'b0));
    if (sipo_pend) chk("sipo", 32'(sipo & mask), 32'(sipo_word));
    sipo_pend = 1'b0;
    acc = v && !r && (q.size() <= W);
    if (r) begin
      q.delete();
    end else begin
      if (has) begin
        if (e.l) begin
          sipo_pend = 1'b1;
          sipo_word = e.w;
        end
        void'(q.pop_front());
      end
      if (acc) begin
        for (int i = W - 1; i >= 0; i--)
          q.push_back('{b: d[i], f: (i == W - 1), l: (i == 0), w: d & mask});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h0, a);
  endtask

  // Hold p_valid with the word until the model says it was taken.
  task automatic send(input logic [7:0] d);
    bit a;
    a = 1'b0;
    for (int t = 0; t < 3 * W + 4 && !a; t++) step(1'b0, 1'b1, d, a);
    if (!a) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 4 * W && q.size() > 0; t++) idle(1);
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic random_run(input int n);
    bit a;
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom()), a);
    end
  endtask

  initial begin
    bit a;
    int gap;
    rst4 = 1'b1; p_valid4 = 1'b0; p_in4 = '0;
    rst8 = 1'b1; p_valid8 = 1'b0; p_in8 = '0;

    // Reset gating: word offered during reset must be ignored.
    step(1'b1, 1'b1, 8'hA, a);
    step(1'b1, 1'b1, 8'hA, a);
    idle(6);

    // Single word 1011.
    send(8'hB);
    drain();
    idle(2);

    // Back-to-back A,5,F; the stream must not gap.
    send(8'hA);
    send(8'h5);
    send(8'hF);
    gap = 0;
    while (q.size() > 0 && gap < 20) begin
      idle(1);
      gap++;
    end
    idle(2);

    // Last-bit bypass: offer 6 exactly in the s_last cycle of the prior word.
    send(8'h1);
    for (int t = 0; t < 8 && q.size() != 1; t++) idle(1);
    chk("bypass_setup", 32'(q.size()), 32'd1);
    step(1'b0, 1'b1, 8'h6, a);
    chk("bypass_accept", 32'(a), 32'd1);
    drain();
    idle(1);

    // Reset mid-word: C in flight, 9 held, reset after two bits.
    send(8'hC);
    send(8'h9);
    idle(1);
    step(1'b1, 1'b0, 8'h0, a);
    idle(3);
    send(8'h3);
    drain();
    idle(2);

    random_run(400);
    drain();
    idle(2);

    // WIDTH=8 instance.
    sel8 = 1'b1;
    W    = 8;
    q.delete();
    sipo_pend = 1'b0;
    step(1'b1, 1'b0, 8'h0, a);
    step(1'b1, 1'b0, 8'h0, a);
    idle(2);
    send(8'hC3);
    drain();
    idle(2);
    send(8'hC3);
    send(8'h5A);
    send(8'h81);
    drain();
    idle(1);
    random_run(400);
    drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_piso_tx

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter that feeds the serial input of the sequential-library `sipo_4` deserializer. It accepts `WIDTH`-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock. Because the bit order is MSB-first, a left-shifting SIPO on the far side holds the original word one cycle after the last bit. A one-entry holding register lets consecutive words stream with no idle bit slots.

## Interface
- `WIDTH`, default 4: word width in bits; legal range is 2 or more.
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `p_in`  in  WIDTH: parallel word to transmit.
- `p_valid`  in  1: `p_in` is valid this cycle.
- `p_ready`  out  1: block can accept a word; a word transfers on any edge where `p_valid && p_ready`.
- `s_out`  out  1: serial data bit, MSB first; driven to 0 whenever `s_valid=0`.
- `s_valid`  out  1: `s_out` carries a live bit this cycle.
- `s_first`  out  1: high on bit WIDTH-1 (the first bit) of each word.
- `s_last`  out  1: high on bit 0 (the last bit) of each word.

## Operation
- Registers:
  - `sh[WIDTH-1:0]`: shift register.
  - `cnt`: bit counter, $clog2(WIDTH) bits.
  - `hold[WIDTH-1:0]` and `hold_full`: one-entry holding register.
  - `state`: one of IDLE, SHIFT.
- Reset values:
  - Registers: state=IDLE, sh=0, cnt=0, hold=0, hold_full=0.
  - Outputs: s_out=0, s_valid=0, s_first=0, s_last=0, p_ready=0 while `rst` is high.
- `p_ready = !hold_full && !rst`. A word presented while `rst` is high is ignored.
- Outputs are decoded from registers only:
  - s_valid = (state==SHIFT).
  - s_out = sh[WIDTH-1] & s_valid.
  - s_first = s_valid && cnt==0.
  - s_last = s_valid && cnt==WIDTH-1.
- IDLE:
  - On accept: sh<=p_in, cnt<=0, go to SHIFT.
  - hold is always empty in IDLE.
- SHIFT, when cnt != WIDTH-1:
  - sh<=sh<<1, cnt<=cnt+1.
  - On accept: hold<=p_in, hold_full<=1.
- SHIFT, when cnt == WIDTH-1 (last bit), in priority order:
  1. If hold_full: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT.
  2. Else, on accept: sh<=p_in directly, bypassing hold; cnt<=0, stay in SHIFT.
  3. Else: go to IDLE, cnt<=0.
- Simultaneous events:
  - Accept is impossible while hold_full=1, so the last-bit reload never collides with a hold write.
- Reset mid-word:
  - Any partially sent word and any held word are discarded.
  - No partial completion and no s_last pulse.
- Bits shifted out of `sh` are discarded. The vacated LSB fills with 0.

## Timing
- Latency: word accepted on edge N drives its first bit (s_first=1) in cycle N+1 and its last bit (s_last=1) in cycle N+WIDTH.
- With a downstream left-shifting SIPO sampling `s_out` every cycle, the SIPO's parallel output equals the word in cycle N+WIDTH+1.
- Throughput: one bit per clock. If p_valid stays high, words run back-to-back with s_valid continuously 1.
- p_ready is high in IDLE, and in SHIFT until hold fills. It drops the cycle after a hold write and returns the cycle after the last-bit reload.
- s_valid deasserts in the cycle after s_last when no further word is pending.

## Structure
- Shared sequential package holds:
  - `piso_state_t` enum {IDLE, SHIFT}.
  - `PISO_WIDTH_DEFAULT = 4`, which matches the 4-bit SIPO.
- Single module; no sub-module is warranted. The holding register and counter are inline.
- Expected size: about 120-180 lines of RTL.

## Test plan
- Reset gating:
  - Stimulus: rst=1 for 2 cycles while p_valid=1, p_in=4'hA.
  - Required: p_ready=0, s_valid=0, and nothing transmitted after release; p_ready=1 in the first cycle with rst=0.
- Single word:
  - Stimulus: accept 4'b1011 on edge N.
  - Required: s_out = 1,0,1,1 in cycles N+1..N+4; s_first at N+1, s_last at N+4; s_valid=0 at N+5; chained `sipo_4` p_out=4'hB at N+5.
- Back-to-back:
  - Stimulus: 4'hA, 4'h5, 4'hF with p_valid held high.
  - Required: 12 consecutive s_valid cycles with no gap; p_ready low while hold is full; serial stream 1010_0101_1111.
- Last-bit bypass:
  - Stimulus: p_valid pulse with 4'h6 exactly in the s_last cycle of the previous word, hold empty.
  - Required: next cycle s_first=1, s_out=0 (the MSB of 4'h6), no idle slot.
- Reset mid-word:
  - Stimulus: accept 4'hC then 4'h9 (the latter held); assert rst after 2 bits.
  - Required: s_valid=0 the next cycle; both words dropped; a later 4'h3 serializes as 0,0,1,1 with correct s_first/s_last.
- Width parameter:
  - Stimulus: WIDTH=8, word 8'hC3.
  - Required: s_out = 1,1,0,0,0,0,1,1; s_last on bit 8; cnt wraps to 0.
